// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle CPU: Moore datapath controls plus a retire counter.
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until MemReady is high.
module multicycle_main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        ALUOp,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  State,
  output logic        Illegal,
  output logic        InstrDone,
  output logic [15:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       adrsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       done;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
      S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
      S_MEMADR:   begin c.srca = 2'b00; c.srcb = 2'b01; end
      S_MEMREAD:  begin c.adrsrc = 1'b1; c.res = 2'b00; end
      S_MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; c.done = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; c.done = 1'b1; end
      S_EXECUTER: begin c.srcb = 2'b00; c.aluop = 1'b1; end
      S_EXECUTEI: begin c.srcb = 2'b01; c.aluop = 1'b1; end
      S_ALUWB:    begin c.res = 2'b00; c.regw = 1'b1; c.done = 1'b1; end
      S_BRANCH:   begin c.srcb = 2'b01; c.res = 2'b10; c.branch = 1'b1; c.done = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t      r_state;
  state_t      w_next;
  ctrl_t       r_ctrl;
  logic [15:0] r_count;
  logic        w_mem_ready;
  logic        w_illegal;
  logic        w_done;

`ifdef MEM_WAIT_EN
  assign w_mem_ready = MemReady;
`else
  logic w_unused_memready;
  assign w_unused_memready = MemReady;
  assign w_mem_ready       = 1'b1;
`endif

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Illegal decode retires in DECODE itself; a stalled store retires only once memory accepts it.
  assign w_illegal = (r_state == S_DECODE) && (Op == 2'b11);
  assign w_done    = (r_ctrl.done && ((r_state != S_MEMWRITE) || w_mem_ready)) || w_illegal;

  // Controls are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_for(S_FETCH);
      r_count <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next);
      if (w_done) r_count <= r_count + 16'h0001;
    end
  end

  assign IRWrite    = r_ctrl.irwrite & w_mem_ready;
  assign NextPC     = r_ctrl.nextpc & w_mem_ready;
  assign RegW       = r_ctrl.regw;
  assign MemW       = r_ctrl.memw;
  assign Branch     = r_ctrl.branch;
  assign ALUOp      = r_ctrl.aluop;
  assign AdrSrc     = r_ctrl.adrsrc;
  assign ALUSrcA    = r_ctrl.srca;
  assign ALUSrcB    = r_ctrl.srcb;
  assign ResultSrc  = r_ctrl.res;
  assign State      = r_state;
  assign Illegal    = w_illegal;
  assign InstrDone  = w_done;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: state sequences, control vectors, counter and reset.
module tb_multicycle_main_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic        MemReady;
  logic        IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  State;
  logic        Illegal, InstrDone;
  logic [15:0] InstrCount;
  logic [14:0] ctrl;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt;

  // {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,AdrSrc}, {ALUSrcA,ALUSrcB,ResultSrc}, {Illegal,InstrDone}
  localparam logic [14:0] C_FETCH   = {7'b1100000, 6'b011010, 2'b00};
  localparam logic [14:0] C_DEC     = {7'b0000000, 6'b011010, 2'b00};
  localparam logic [14:0] C_DEC_ILL = {7'b0000000, 6'b011010, 2'b11};
  localparam logic [14:0] C_MEMADR  = {7'b0000000, 6'b000100, 2'b00};
  localparam logic [14:0] C_MEMREAD = {7'b0000001, 6'b000000, 2'b00};
  localparam logic [14:0] C_MEMWB   = {7'b0010000, 6'b000001, 2'b01};
  localparam logic [14:0] C_MEMWR   = {7'b0001001, 6'b000000, 2'b01};
  localparam logic [14:0] C_EXR     = {7'b0000010, 6'b000000, 2'b00};
  localparam logic [14:0] C_EXI     = {7'b0000010, 6'b000100, 2'b00};
  localparam logic [14:0] C_ALUWB   = {7'b0010000, 6'b000000, 2'b01};
  localparam logic [14:0] C_BR      = {7'b0000100, 6'b000110, 2'b01};

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .ALUOp(ALUOp), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .State(State), .Illegal(Illegal), .InstrDone(InstrDone),
    .InstrCount(InstrCount)
  );

  assign ctrl = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, Illegal, InstrDone};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", State); end
    n_checks++;
    if (InstrCount !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h want 0000", InstrCount); end
    n_checks++;
    if (ctrl !== C_FETCH) begin n_fail++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_FETCH); end
    tick; tick;
    n_checks++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL reset_hold_state got %0d want 0", State); end
    reset = 1'b0;
    exp_cnt = 16'h0000;
    #1;
  endtask

  task automatic test_dataproc;
    logic [3:0]  es [0:4];
    logic [14:0] ec [0:4];
    for (int k = 0; k < 2; k++) begin
      Op = 2'b00;
      if (k == 0) begin
        Funct = 6'b100000;
        es = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        ec = '{C_FETCH, C_DEC, C_EXI, C_ALUWB, C_FETCH};
      end else begin
        Funct = 6'b011111;
        es = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        ec = '{C_FETCH, C_DEC, C_EXR, C_ALUWB, C_FETCH};
      end
      #1;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (State !== es[i]) begin n_fail++; $display("FAIL dataproc%0d_state step %0d got %0d want %0d", k, i, State, es[i]); end
        n_checks++;
        if (ctrl !== ec[i]) begin n_fail++; $display("FAIL dataproc%0d_ctrl step %0d got %b want %b", k, i, ctrl, ec[i]); end
        if (i < 4) tick;
      end
      exp_cnt = exp_cnt + 16'h0001;
      n_checks++;
      if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL dataproc%0d_count got %h want %h", k, InstrCount, exp_cnt); end
    end
  endtask

  task automatic test_load_store;
    logic [3:0]  es [0:5];
    logic [14:0] ec [0:5];
    int          n;
    for (int k = 0; k < 2; k++) begin
      Op = 2'b01;
      if (k == 0) begin
        Funct = 6'b000001; n = 6;
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        ec = '{C_FETCH, C_DEC, C_MEMADR, C_MEMREAD, C_MEMWB, C_FETCH};
      end else begin
        Funct = 6'b111110; n = 5;
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0};
        ec = '{C_FETCH, C_DEC, C_MEMADR, C_MEMWR, C_FETCH, C_FETCH};
      end
      #1;
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (State !== es[i]) begin n_fail++; $display("FAIL ldst%0d_state step %0d got %0d want %0d", k, i, State, es[i]); end
        n_checks++;
        if (ctrl !== ec[i]) begin n_fail++; $display("FAIL ldst%0d_ctrl step %0d got %b want %b", k, i, ctrl, ec[i]); end
        if (i < n - 1) tick;
      end
      exp_cnt = exp_cnt + 16'h0001;
      n_checks++;
      if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL ldst%0d_count got %h want %h", k, InstrCount, exp_cnt); end
    end
  endtask

  task automatic test_branch_illegal;
    logic [3:0]  es [0:3];
    logic [14:0] ec [0:3];
    int          n;
    for (int k = 0; k < 2; k++) begin
      Funct = 6'b101010;
      if (k == 0) begin
        Op = 2'b10; n = 4;
        es = '{4'd0, 4'd1, 4'd9, 4'd0};
        ec = '{C_FETCH, C_DEC, C_BR, C_FETCH};
      end else begin
        Op = 2'b11; n = 3;
        es = '{4'd0, 4'd1, 4'd0, 4'd0};
        ec = '{C_FETCH, C_DEC_ILL, C_FETCH, C_FETCH};
      end
      #1;
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (State !== es[i]) begin n_fail++; $display("FAIL brill%0d_state step %0d got %0d want %0d", k, i, State, es[i]); end
        n_checks++;
        if (ctrl !== ec[i]) begin n_fail++; $display("FAIL brill%0d_ctrl step %0d got %b want %b", k, i, ctrl, ec[i]); end
        if (i < n - 1) tick;
      end
      exp_cnt = exp_cnt + 16'h0001;
      n_checks++;
      if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL brill%0d_count got %h want %h", k, InstrCount, exp_cnt); end
    end
  endtask

  // Op/Funct changes outside DECODE/MEMADR must not disturb a load in flight.
  task automatic test_ignore_inputs;
    logic [3:0] es [0:5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    Op = 2'b01; Funct = 6'b000001;
`ifndef MEM_WAIT_EN
    MemReady = 1'b0;
`endif
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin Op = 2'b11; Funct = 6'b000000; #1; end
      if (i == 4) begin Op = 2'b00; Funct = 6'b100000; #1; end
      n_checks++;
      if (State !== es[i]) begin n_fail++; $display("FAIL ignore_state step %0d got %0d want %0d", i, State, es[i]); end
      if (i < 5) tick;
    end
    n_checks++;
    if (Illegal !== 1'b0) begin n_fail++; $display("FAIL ignore_illegal got %b want 0", Illegal); end
    exp_cnt = exp_cnt + 16'h0001;
    n_checks++;
    if (InstrCount !== exp_cnt) begin n_fail++; $display("FAIL ignore_count got %h want %h", InstrCount, exp_cnt); end
    MemReady = 1'b1;
  endtask

  task automatic test_reset_mid_memread;
    Op = 2'b01; Funct = 6'b000001;
    #1;
    tick; tick; tick;
    n_checks++;
    if (State !== 4'd3) begin n_fail++; $display("FAIL midrst_pre_state got %0d want 3", State); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL midrst_state got %0d want 0", State); end
    n_checks++;
    if (InstrCount !== 16'h0000) begin n_fail++; $display("FAIL midrst_count got %h want 0000", InstrCount); end
    n_checks++;
    if (ctrl !== C_FETCH) begin n_fail++; $display("FAIL midrst_ctrl got %b want %b", ctrl, C_FETCH); end
    tick;
    reset = 1'b0;
    exp_cnt = 16'h0000;
    #1;
  endtask

  task automatic test_count_wrap;
    force dut.r_count = 16'hFFFE;
    #1;
    release dut.r_count;
    Op = 2'b11; Funct = 6'd0;
    #1;
    tick;
    n_checks++;
    if (Illegal !== 1'b1) begin n_fail++; $display("FAIL wrap_illegal got %b want 1", Illegal); end
    tick;
    n_checks++;
    if (InstrCount !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", InstrCount); end
    Op = 2'b10;
    #1;
    tick; tick; tick;
    n_checks++;
    if (State !== 4'd0) begin n_fail++; $display("FAIL wrap_state got %0d want 0", State); end
    n_checks++;
    if (InstrCount !== 16'h0000) begin n_fail++; $display("FAIL wrap_count got %h want 0000", InstrCount); end
    exp_cnt = 16'h0000;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait;
    Op = 2'b11; Funct = 6'd0; MemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (State !== 4'd0 || IRWrite !== 1'b0) begin n_fail++; $display("FAIL wait_fetch step %0d got state %0d irw %b want 0/0", i, State, IRWrite); end
      tick;
    end
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1) begin n_fail++; $display("FAIL wait_fetch_go got state %0d irw %b npc %b want 0/1/1", State, IRWrite, NextPC); end
    tick; tick;
    Op = 2'b01;
    #1;
    tick; tick; tick;
    MemReady = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (State !== 4'd5 || MemW !== 1'b1 || InstrDone !== 1'b0) begin n_fail++; $display("FAIL wait_store step %0d got state %0d memw %b done %b want 5/1/0", i, State, MemW, InstrDone); end
      tick;
    end
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (InstrDone !== 1'b1 || MemW !== 1'b1) begin n_fail++; $display("FAIL wait_store_go got done %b memw %b want 1/1", InstrDone, MemW); end
    tick;
    exp_cnt = exp_cnt + 16'h0002;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt) begin n_fail++; $display("FAIL wait_end got state %0d count %h want 0/%h", State, InstrCount, exp_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_dataproc;
    test_load_store;
    test_branch_illegal;
    test_ignore_inputs;
    test_reset_mid_memread;
    test_count_wrap;
`ifdef MEM_WAIT_EN
    test_mem_wait;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
